// File: rtl/fft_frame_source.sv
// fft_frame_source: replays a stored N-point complex frame over a valid/ready stream.
// Supports single-shot or continuous replay, bit-reversed ordering and a fixed inter-frame gap.
`default_nettype none

module fft_frame_source #(
    parameter int DATA_W     = 9,
    parameter int LOG2N      = 5,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [LOG2N-1:0]         wr_addr,
    input  logic signed [DATA_W-1:0] wr_re,
    input  logic signed [DATA_W-1:0] wr_im,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     bitrev,
    input  logic                     stop,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]         out_index,
    output logic                     out_sof,
    output logic                     out_eof,
    output logic                     busy,
    output logic [15:0]              frames_done
);

    localparam int               N        = 1 << LOG2N;
    localparam logic [LOG2N-1:0] K_LAST   = LOG2N'(N - 1);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [7:0]       GAP_LAST = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic signed [DATA_W-1:0] mem_re [N];
    logic signed [DATA_W-1:0] mem_im [N];

    state_t                   state_q;
    logic [LOG2N-1:0]         k_q;
    logic [7:0]               gap_q;
    logic                     mode_q, bitrev_q, stop_q;
    logic                     out_valid_q, out_sof_q, out_eof_q;
    logic signed [DATA_W-1:0] out_re_q, out_im_q;
    logic [LOG2N-1:0]         out_index_q;
    logic [15:0]              frames_q;

    logic                     xfer, stop_pend, load_en, rev_sel;
    logic [LOG2N-1:0]         k_d, rd_addr;

    function automatic logic [LOG2N-1:0] f_rev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    // No reset on the sample store; reads elsewhere see the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[wr_addr] <= wr_re;
            mem_im[wr_addr] <= wr_im;
        end
    end

    always_comb begin
        xfer      = out_valid_q & out_ready;
        stop_pend = stop_q | stop;
        load_en   = 1'b0;
        k_d       = '0;
        rev_sel   = bitrev_q;
        case (state_q)
            S_IDLE: begin
                load_en = start;
                rev_sel = bitrev;
            end
            S_RUN: begin
                if (xfer) begin
                    if (k_q != K_LAST) begin
                        load_en = 1'b1;
                        k_d     = k_q + 1'b1;
                    end else if (mode_q && !stop_pend && !HAS_GAP) begin
                        load_en = 1'b1;
                    end
                end
            end
            S_GAP:   load_en = (gap_q == 8'd0) && !stop_pend;
            default: load_en = 1'b0;
        endcase
        rd_addr = rev_sel ? f_rev(k_d) : k_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            gap_q       <= 8'd0;
            mode_q      <= 1'b0;
            bitrev_q    <= 1'b0;
            stop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_index_q <= '0;
            frames_q    <= 16'd0;
        end else begin
            if (state_q != S_IDLE && stop) stop_q <= 1'b1;
            if (load_en) begin
                k_q         <= k_d;
                out_re_q    <= mem_re[rd_addr];
                out_im_q    <= mem_im[rd_addr];
                out_index_q <= k_d;
                out_sof_q   <= (k_d == '0);
                out_eof_q   <= (k_d == K_LAST);
                out_valid_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_RUN;
                        mode_q   <= mode;
                        bitrev_q <= bitrev;
                        stop_q   <= 1'b0;
                        frames_q <= 16'd0;
                    end
                end
                S_RUN: begin
                    if (xfer && k_q == K_LAST) begin
                        if (frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
                        if (!mode_q || stop_pend) begin
                            state_q     <= S_IDLE;
                            stop_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_sof_q   <= 1'b0;
                            out_eof_q   <= 1'b0;
                        end else if (HAS_GAP) begin
                            state_q     <= S_GAP;
                            gap_q       <= GAP_LAST;
                            out_valid_q <= 1'b0;
                            out_sof_q   <= 1'b0;
                            out_eof_q   <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == 8'd0) begin
                        if (stop_pend) begin
                            state_q <= S_IDLE;
                            stop_q  <= 1'b0;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_re      = out_re_q;
    assign out_im      = out_im_q;
    assign out_index   = out_index_q;
    assign out_sof     = out_sof_q;
    assign out_eof     = out_eof_q;
    assign busy        = (state_q != S_IDLE);
    assign frames_done = frames_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_source.sv
// tb_fft_frame_source: directed self-checking bench for fft_frame_source (N=32, DATA_W=9, gap=2).
`default_nettype none

module tb_fft_frame_source;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [4:0]        wr_addr = '0;
    logic signed [8:0] wr_re = '0, wr_im = '0;
    logic              start = 1'b0, mode = 1'b0, bitrev = 1'b0, stop = 1'b0;
    logic              out_ready = 1'b1;
    logic              out_valid, out_sof, out_eof, busy;
    logic signed [8:0] out_re, out_im;
    logic [4:0]        out_index;
    logic [15:0]       frames_done;

    int n_checks = 0;
    int n_pass   = 0;

    fft_frame_source #(.DATA_W(9), .LOG2N(5), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_re(wr_re), .wr_im(wr_im),
        .start(start), .mode(mode), .bitrev(bitrev), .stop(stop), .out_ready(out_ready),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_index(out_index),
        .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input int re, input int im);
        wr_en = 1'b1; wr_addr = 5'(a); wr_re = 9'(re); wr_im = 9'(im);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic m, input logic b);
        start = 1'b1; mode = m; bitrev = b;
        tick();
        start = 1'b0; mode = 1'b0; bitrev = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (busy && c < bound) begin tick(); c++; end
        check("idle_timeout", busy, 0);
    endtask

    function automatic int rev5(input int k);
        int r = 0;
        for (int i = 0; i < 5; i++) r |= ((k >> i) & 1) << (4 - i);
        return r;
    endfunction

    initial begin
        int pat[6] = '{1, 0, 0, 1, 0, 1};
        int cnt, cyc, held_re, held_idx, sofs, eofs, gap_len;
        bit stalled, gap_on, stopped;

        tick(); tick();
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_re", out_re, 0);
        check("rst_im", out_im, 0);
        check("rst_index", out_index, 0);
        check("rst_sof", out_sof, 0);
        check("rst_eof", out_eof, 0);
        check("rst_busy", busy, 0);
        check("rst_frames", frames_done, 0);

        for (int k = 0; k < 32; k++) write(k, k, -k);

        // Linear single frame
        out_ready = 1'b1;
        pulse_start(1'b0, 1'b0);
        check("lin_busy", busy, 1);
        for (int k = 0; k < 32; k++) begin
            check("lin_valid", out_valid, 1);
            check("lin_re", out_re, k);
            check("lin_im", out_im, -k);
            check("lin_index", out_index, k);
            check("lin_sof", out_sof, (k == 0));
            check("lin_eof", out_eof, (k == 31));
            tick();
        end
        check("lin_end_valid", out_valid, 0);
        check("lin_end_busy", busy, 0);
        check("lin_frames", frames_done, 1);

        // Bit-reversed single frame
        pulse_start(1'b0, 1'b1);
        for (int k = 0; k < 32; k++) begin
            check("rev_re", out_re, rev5(k));
            check("rev_im", out_im, -rev5(k));
            check("rev_index", out_index, k);
            tick();
        end
        check("rev_end_busy", busy, 0);

        // Back-pressure
        pulse_start(1'b0, 1'b0);
        cnt = 0; cyc = 0; stalled = 0; held_re = 0; held_idx = 0;
        while (cnt < 32 && cyc < 300) begin
            if (out_valid) begin
                if (stalled) begin
                    check("stall_hold_re", out_re, held_re);
                    check("stall_hold_idx", out_index, held_idx);
                end
                out_ready = pat[cyc % 6][0];
                if (out_ready) begin
                    check("stall_re", out_re, cnt);
                    check("stall_idx", out_index, cnt);
                    cnt++;
                    stalled = 0;
                end else begin
                    stalled = 1; held_re = out_re; held_idx = out_index;
                end
            end else begin
                out_ready = 1'b1;
            end
            tick(); cyc++;
        end
        out_ready = 1'b1;
        check("stall_count", cnt, 32);
        check("stall_end_busy", busy, 0);

        // Continuous with gap, stop mid frame 2
        pulse_start(1'b1, 1'b0);
        sofs = 0; eofs = 0; gap_len = 0; gap_on = 0; stopped = 0; cyc = 0;
        while (busy && cyc < 300) begin
            stop = 1'b0;
            if (out_valid) begin
                if (out_sof) begin
                    sofs++;
                    if (gap_on) begin check("gap_len", gap_len, 2); gap_on = 0; end
                end
                if (out_eof) begin
                    eofs++;
                    if (eofs == 1) begin gap_on = 1; gap_len = 0; end
                end
                if (sofs == 2 && out_index == 10 && !stopped) begin stop = 1'b1; stopped = 1; end
            end else if (gap_on) begin
                gap_len++;
            end
            tick(); cyc++;
        end
        stop = 1'b0;
        check("cont_busy", busy, 0);
        check("cont_frames", frames_done, 2);
        check("cont_sofs", sofs, 2);
        check("cont_eofs", eofs, 2);
        check("cont_valid", out_valid, 0);

        // Stop during gap
        pulse_start(1'b1, 1'b0);
        cyc = 0;
        while (!(out_valid && out_eof) && cyc < 100) begin tick(); cyc++; end
        check("sg_eof_seen", out_eof, 1);
        tick();
        check("sg_in_gap", out_valid, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("sg_gap2_valid", out_valid, 0);
        tick();
        check("sg_busy", busy, 0);
        check("sg_valid", out_valid, 0);
        check("sg_frames", frames_done, 1);

        // Extreme values and write/hold interaction
        write(0, -256, 255);
        pulse_start(1'b0, 1'b0);
        check("ext_re", out_re, -256);
        check("ext_im", out_im, 255);
        for (int i = 0; i < 4; i++) tick();
        check("rbw_idx4", out_index, 4);
        write(5, 100, -100);
        check("rbw_idx5", out_index, 5);
        check("rbw_re_old", out_re, 5);
        check("rbw_im_old", out_im, -5);
        out_ready = 1'b0;
        write(5, 50, -50);
        check("hold_valid", out_valid, 1);
        check("hold_re", out_re, 5);
        check("hold_im", out_im, -5);
        tick();
        check("hold_re2", out_re, 5);
        check("hold_idx", out_index, 5);
        out_ready = 1'b1;
        wait_idle(64);
        pulse_start(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("new5_idx", out_index, 5);
        check("new5_re", out_re, 50);
        check("new5_im", out_im, -50);
        wait_idle(64);

        // Reset mid-frame, then start-while-busy is ignored
        pulse_start(1'b1, 1'b0);
        cyc = 0;
        while (!(frames_done == 16'd1 && out_valid && out_index == 5'd10) && cyc < 200) begin tick(); cyc++; end
        check("mr_pre_frames", frames_done, 1);
        check("mr_pre_idx", out_index, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", out_valid, 0);
        check("mr_re", out_re, 0);
        check("mr_im", out_im, 0);
        check("mr_index", out_index, 0);
        check("mr_sof", out_sof, 0);
        check("mr_eof", out_eof, 0);
        check("mr_busy", busy, 0);
        check("mr_frames", frames_done, 0);
        tick();
        check("mr_stay_idle", busy, 0);
        pulse_start(1'b0, 1'b0);
        check("rs_idx", out_index, 0);
        check("rs_sof", out_sof, 1);
        check("rs_busy", busy, 1);
        check("rs_frames", frames_done, 0);
        tick(); tick();
        check("rs_idx2", out_index, 2);
        pulse_start(1'b1, 1'b1);
        check("sb_idx", out_index, 3);
        check("sb_re", out_re, 3);
        wait_idle(64);
        check("sb_frames", frames_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_frame_source.md
# fft_frame_source

Parametrised, synthesizable frame source that replays a stored N-point complex frame into the MDC FFT input, one sample per accepted transfer. Replaces hard-coded per-cycle stimulus loops: samples are loaded through a write port, then streamed with a valid/ready handshake. Streaming runs in single-shot or continuous mode, with optional bit-reversed ordering and a programmable inter-frame gap. Sits directly in front of the `fft` core, in simulation benches and on-chip self-test.

## Interface
- `DATA_W`, default 9: signed sample width (re and im).
- `LOG2N`, default 5: log2 of frame length; N = 2**LOG2N.
- `GAP_CYCLES`, default 0: idle cycles (out_valid=0) between frames in continuous mode. Range 0..255.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `wr_en`  in  1: write strobe for sample memory.
- `wr_addr`  in  LOG2N: write address.
- `wr_re`, `wr_im`  in  DATA_W each: signed write data.
- `start`  in  1: one-cycle pulse that begins streaming; honoured only in IDLE.
- `mode`  in  1: 0 = single frame, 1 = continuous. Sampled on accepted start.
- `bitrev`  in  1: 1 = read addresses in bit-reversed order. Sampled on accepted start.
- `stop`  in  1: pulse; continuous run ends after the current frame.
- `out_ready`  in  1: downstream accepts the sample.
- `out_valid`  out  1: sample presented.
- `out_re`, `out_im`  out  DATA_W each: signed sample.
- `out_index`  out  LOG2N: stream position k (0..N-1) of the presented sample.
- `out_sof`, `out_eof`  out  1: asserted with out_valid at k=0 / k=N-1.
- `busy`  out  1: high in RUN and GAP.
- `frames_done`  out  16: completed frames; saturates at 16'hFFFF.

## Operation
- States:
  - IDLE: out_valid=0.
  - RUN: presenting samples.
  - GAP: inter-frame idle.
- IDLE→RUN on start. In the same cycle, latch mode and bitrev, clear frames_done and any pending stop, and set k=0.
- Read address = k, or the LOG2N-bit bit-reverse of k when bitrev is latched. The sample is loaded into output registers when k is set or advanced.
- Transfer = out_valid & out_ready. On transfer with k<N-1: k←k+1 and the next sample is loaded.
- Transfer at k=N-1 (EOF): frames_done increments (saturating), then:
  - single mode or stop pending → IDLE;
  - continuous, GAP_CYCLES=0 → stay in RUN, k←0;
  - continuous, GAP_CYCLES>0 → GAP for exactly GAP_CYCLES cycles, then RUN with k=0.
- stop is latched whenever busy and held until EOF. A stop during GAP → IDLE at end of GAP, without starting a new frame. A stop in IDLE is ignored.
- start while busy is ignored.
- Memory has N entries. It is writable in any state, is not cleared by reset, and is read-before-write.
  - A write in cycle t to an address that is loaded in cycle t yields the old data.
  - The sample already held in the output registers is never altered by writes.
- Output data is held stable while out_valid=1 and out_ready=0.
- Arithmetic: pure pass-through. No scaling or truncation of the DATA_W signed samples.

## Timing
- Reset values: out_valid=0, out_re=0, out_im=0, out_index=0, out_sof=0, out_eof=0, busy=0, frames_done=0, state IDLE. Latched mode, bitrev and stop are cleared.
- Reset mid-frame: outputs take reset values the cycle after rst is sampled high. The frame is abandoned and frames_done is cleared.
- start sampled at edge t → out_valid=1, out_index=0, out_sof=1 after edge t, with busy=1 in the same cycle.
- Throughput 1 sample/cycle with out_ready held high. A transfer at edge t presents the next sample after edge t (zero bubble).
- Single mode: EOF transfer at edge t → out_valid=0 and busy=0 after edge t, frames_done updated in the same cycle.
- Continuous mode, gap G>0: EOF transfer at edge t → out_valid=0 for G cycles, then SOF presented.

## Test plan
- Load re=k, im=-k for k=0..31. Pulse start with mode=0, bitrev=0, out_ready=1 → 32 consecutive samples re=0..31, im=0..-31. out_sof only at k=0, out_eof only at k=31. Then busy=0 and frames_done=1.
- Same load with bitrev=1 → re sequence 0,16,8,24,4,20,12,28,... ending at 31. out_index runs 0..31.
- out_ready pattern 1,0,0,1,0,1,... → every stalled cycle holds identical data. The received stream is exactly 0..31 with no loss or duplicate.
- mode=1, GAP_CYCLES=2, stop pulsed mid-frame 2 → frame 2 completes, then IDLE with frames_done=2. Exactly 2 cycles of out_valid=0 between the first EOF and the second SOF.
- Load entry 0 = (-256, 255), DATA_W=9 → output exactly -256/255. Writing address 5 while k=5 is held leaves the held sample unchanged.
- rst asserted at k=10 → all outputs zero the next cycle. A subsequent start restarts at k=0 with frames_done=0. A start pulsed while busy has no effect.
